acc_alu_unit: RTL and testbench

- Registered accumulator/carry execution unit: the sequential successor of the combinational 4-bit ALU.
- Owns ACC and CY, parametrised in data width, and accepts one operation per valid/ready handshake.
- Executes the 4004 arithmetic and accumulator-group (F_) operations, including multi-digit BCD adjust over several cycles.
- Sits between the decoder (op, opa) and the register file (writeback via out_result).

---
 rtl/acc_alu_unit.sv | 184 ++++++++++++++++++
 tb/tb_acc_alu_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_unit.sv
// acc_alu_unit: registered ACC/CY execution unit for 4004 arithmetic and accumulator-group ops.
// Define ACC_ALU_BCD_EN to enable the multi-cycle DAA (DAA_ITER state) and the KBP decode.
module acc_alu_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [3:0]       op_sub,
   input  logic [WIDTH-1:0] opa,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] acc,
   output logic             cy,
   output logic             zero,
   output logic             busy
);
   localparam logic [3:0] OP_ADD = 4'h8;
   localparam logic [3:0] OP_SUB = 4'h9;
   localparam logic [3:0] OP_LD  = 4'hA;
   localparam logic [3:0] OP_XCH = 4'hB;
   localparam logic [3:0] OP_LDM = 4'hD;
   localparam logic [3:0] OP_F   = 4'hF;

   localparam logic [3:0] F_CLB = 4'h0;
   localparam logic [3:0] F_CLC = 4'h1;
   localparam logic [3:0] F_IAC = 4'h2;
   localparam logic [3:0] F_CMC = 4'h3;
   localparam logic [3:0] F_CMA = 4'h4;
   localparam logic [3:0] F_RAL = 4'h5;
   localparam logic [3:0] F_RAR = 4'h6;
   localparam logic [3:0] F_TCC = 4'h7;
   localparam logic [3:0] F_DAC = 4'h8;
   localparam logic [3:0] F_TCS = 4'h9;
   localparam logic [3:0] F_STC = 4'hA;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             cy_q, cy_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH:0]   add_sum, sub_sum;
   logic             accept;

`ifdef ACC_ALU_BCD_EN
   localparam logic [3:0] F_DAA = 4'hB;
   localparam logic [3:0] F_KBP = 4'hC;
   localparam int unsigned NDIG = WIDTH / 4;
   localparam int unsigned DW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {S_IDLE, S_DAA_ITER} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dig_q, dig_d;
   logic          dc_q, dc_d;
   logic [3:0]    digit;
   logic [5:0]    adj;
   logic [3:0]    kbp;

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q == S_DAA_ITER);

   // Digit adjust: carry from the previous digit's +6 ripples in; digit 0 uses CY as the force flag.
   always_comb begin
      digit = acc_q[4*int'(dig_q) +: 4];
      adj   = 6'(digit) + ((dig_q == '0) ? 6'd0 : 6'(dc_q));
      if ((adj > 6'd9) || ((dig_q == '0) && dc_q)) begin
         adj = adj + 6'd6;
      end
   end

   // Keyboard process: one-hot low nibble to key number, 15 when not one-hot.
   always_comb begin
      case (acc_q[3:0])
         4'h0:    kbp = 4'h0;
         4'h1:    kbp = 4'h1;
         4'h2:    kbp = 4'h2;
         4'h4:    kbp = 4'h3;
         4'h8:    kbp = 4'h4;
         default: kbp = 4'hF;
      endcase
   end
`else
   assign in_ready = 1'b1;
   assign busy     = 1'b0;
`endif

   assign accept  = in_valid & in_ready;
   assign add_sum = {1'b0, acc_q} + {1'b0, opa} + (WIDTH+1)'(cy_q);
   assign sub_sum = {1'b0, acc_q} + {1'b0, ~opa} + (WIDTH+1)'(cy_q);

   always_comb begin
      acc_d        = acc_q;
      cy_d         = cy_q;
      out_valid_d  = 1'b0;
      out_result_d = out_result_q;
`ifdef ACC_ALU_BCD_EN
      state_d      = state_q;
      dig_d        = dig_q;
      dc_d         = dc_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         case (op)
            OP_ADD:        {cy_d, acc_d} = add_sum;
            OP_SUB:        {cy_d, acc_d} = sub_sum;
            OP_LD, OP_LDM: acc_d = opa;
            OP_XCH:        acc_d = opa;
            OP_F: begin
               case (op_sub)
                  F_CLB: begin acc_d = '0; cy_d = 1'b0; end
                  F_CLC: cy_d = 1'b0;
                  F_IAC: {cy_d, acc_d} = {1'b0, acc_q} + (WIDTH+1)'(1);
                  F_CMC: cy_d = ~cy_q;
                  F_CMA: acc_d = ~acc_q;
                  F_RAL: {cy_d, acc_d} = {acc_q, cy_q};
                  F_RAR: {acc_d, cy_d} = {cy_q, acc_q};
                  F_TCC: begin acc_d = WIDTH'(cy_q); cy_d = 1'b0; end
                  F_DAC: begin acc_d = acc_q - WIDTH'(1); cy_d = |acc_q; end
                  F_TCS: begin acc_d = cy_q ? WIDTH'(4'd10) : WIDTH'(4'd9); cy_d = 1'b0; end
                  F_STC: cy_d = 1'b1;
`ifdef ACC_ALU_BCD_EN
                  F_DAA: begin
                     state_d     = S_DAA_ITER;
                     dig_d       = '0;
                     dc_d        = cy_q;
                     out_valid_d = 1'b0;
                  end
                  F_KBP: acc_d = WIDTH'(kbp);
`endif
                  default: ;
               endcase
            end
            default: ;
         endcase
         out_result_d = (op == OP_XCH) ? acc_q : acc_d;
      end
`ifdef ACC_ALU_BCD_EN
      if (state_q == S_DAA_ITER) begin
         acc_d[4*int'(dig_q) +: 4] = adj[3:0];
         dc_d  = |adj[5:4];
         dig_d = dig_q + 1'b1;
         if (dig_q == DW'(NDIG - 1)) begin
            state_d      = S_IDLE;
            cy_d         = cy_q | (|adj[5:4]);
            out_valid_d  = 1'b1;
            out_result_d = acc_d;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         cy_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
`ifdef ACC_ALU_BCD_EN
         state_q      <= S_IDLE;
         dig_q        <= '0;
         dc_q         <= 1'b0;
`endif
      end else begin
         acc_q        <= acc_d;
         cy_q         <= cy_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
`ifdef ACC_ALU_BCD_EN
         state_q      <= state_d;
         dig_q        <= dig_d;
         dc_q         <= dc_d;
`endif
      end
   end

   assign acc        = acc_q;
   assign cy         = cy_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign zero       = (acc_q == '0);

endmodule

// File: tb/tb_acc_alu_unit.sv
// Directed bench for acc_alu_unit: a 4-bit and an 8-bit instance on a shared clock and reset.
// Expectations for DAA/KBP follow whether ACC_ALU_BCD_EN is defined for the build.
module tb_acc_alu_unit;
   logic       clk, rst_n;
   logic       v4, v8;
   logic [3:0] op4, sub4, op8, sub8;
   logic [3:0] opa4;
   logic [7:0] opa8;
   logic       rdy4, ov4, cy4, z4, busy4;
   logic [3:0] res4, acc4;
   logic       rdy8, ov8, cy8, z8, busy8;
   logic [7:0] res8, acc8;
   int         n_cmp, n_err;

   acc_alu_unit #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .op(op4), .op_sub(sub4),
      .opa(opa4), .out_valid(ov4), .out_result(res4), .acc(acc4), .cy(cy4), .zero(z4), .busy(busy4)
   );

   acc_alu_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .op(op8), .op_sub(sub8),
      .opa(opa8), .out_valid(ov8), .out_result(res8), .acc(acc8), .cy(cy8), .zero(z8), .busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one op to the 4-bit unit for one edge; returns 1ns after that edge.
   task automatic go4(input logic [3:0] o, input logic [3:0] s, input logic [3:0] a);
      v4 = 1'b1; op4 = o; sub4 = s; opa4 = a;
      @(posedge clk); #1;
      v4 = 1'b0;
   endtask

   task automatic go8(input logic [3:0] o, input logic [3:0] s, input logic [7:0] a);
      v8 = 1'b1; op8 = o; sub8 = s; opa8 = a;
      @(posedge clk); #1;
      v8 = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({acc4, cy4, z4, rdy4, ov4, busy4, res4} !== {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
         n_err++;
         $display("FAIL reset4: acc,cy,z,rdy,ov,busy,res got %h %b %b %b %b %b %h want 0 0 1 1 0 0 0",
                  acc4, cy4, z4, rdy4, ov4, busy4, res4);
      end
      n_cmp++;
      if ({acc8, cy8, z8, rdy8, ov8, busy8, res8} !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset8: acc,cy,z,rdy,ov,busy,res got %h %b %b %b %b %b %h want 00 0 1 1 0 0 00",
                  acc8, cy8, z8, rdy8, ov8, busy8, res8);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      go4(4'hD, 4'h0, 4'h7);
      n_cmp++;
      if ({ov4, acc4, cy4, res4} !== {1'b1, 4'h7, 1'b0, 4'h7}) begin
         n_err++; $display("FAIL ldm7: ov,acc,cy,res got %b %h %b %h want 1 7 0 7", ov4, acc4, cy4, res4);
      end
      go4(4'h8, 4'h0, 4'h9);
      n_cmp++;
      if ({ov4, acc4, cy4, z4, res4} !== {1'b1, 4'h0, 1'b1, 1'b1, 4'h0}) begin
         n_err++; $display("FAIL add9: ov,acc,cy,z,res got %b %h %b %b %h want 1 0 1 1 0", ov4, acc4, cy4, z4, res4);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ov4, acc4, cy4} !== {1'b0, 4'h0, 1'b1}) begin
         n_err++; $display("FAIL idle_after_add: ov,acc,cy got %b %h %b want 0 0 1", ov4, acc4, cy4);
      end
      // 8-bit width wraps modulo 256
      go8(4'hF, 4'h0, 8'h00);
      go8(4'hA, 4'h0, 8'hF0);
      go8(4'h8, 4'h0, 8'h25);
      n_cmp++;
      if ({ov8, acc8, cy8, res8} !== {1'b1, 8'h15, 1'b1, 8'h15}) begin
         n_err++; $display("FAIL add8: ov,acc,cy,res got %b %h %b %h want 1 15 1 15", ov8, acc8, cy8, res8);
      end
   endtask

   task automatic test_sub;
      go4(4'hF, 4'hA, 4'h0);
      go4(4'hD, 4'h0, 4'h3);
      go4(4'h9, 4'h0, 4'h5);
      n_cmp++;
      if ({ov4, acc4, cy4} !== {1'b1, 4'hE, 1'b0}) begin
         n_err++; $display("FAIL sub3m5: ov,acc,cy got %b %h %b want 1 e 0", ov4, acc4, cy4);
      end
      go4(4'hD, 4'h0, 4'h5);
      go4(4'hF, 4'hA, 4'h0);
      go4(4'h9, 4'h0, 4'h3);
      n_cmp++;
      if ({ov4, acc4, cy4} !== {1'b1, 4'h2, 1'b1}) begin
         n_err++; $display("FAIL sub5m3: ov,acc,cy got %b %h %b want 1 2 1", ov4, acc4, cy4);
      end
   endtask

   task automatic test_xch_ral_tcs;
      go4(4'hD, 4'h0, 4'hA);
      go4(4'hB, 4'h0, 4'h3);
      n_cmp++;
      if ({ov4, res4, acc4} !== {1'b1, 4'hA, 4'h3}) begin
         n_err++; $display("FAIL xch: ov,res,acc got %b %h %h want 1 a 3", ov4, res4, acc4);
      end
      go4(4'hD, 4'h0, 4'h8);
      go4(4'hF, 4'hA, 4'h0);
      go4(4'hF, 4'h5, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'h1, 1'b1}) begin
         n_err++; $display("FAIL ral: acc,cy got %h %b want 1 1", acc4, cy4);
      end
      go4(4'hF, 4'h9, 4'h0);
      n_cmp++;
      if ({acc4, cy4, res4} !== {4'hA, 1'b0, 4'hA}) begin
         n_err++; $display("FAIL tcs1: acc,cy,res got %h %b %h want a 0 a", acc4, cy4, res4);
      end
      go4(4'hF, 4'h9, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'h9, 1'b0}) begin
         n_err++; $display("FAIL tcs0: acc,cy got %h %b want 9 0", acc4, cy4);
      end
   endtask

   task automatic test_group_ops;
      go4(4'hD, 4'h0, 4'hA);
      go4(4'hF, 4'h6, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'h5, 1'b0}) begin
         n_err++; $display("FAIL rar: acc,cy got %h %b want 5 0", acc4, cy4);
      end
      go4(4'hF, 4'h4, 4'h0);
      n_cmp++;
      if (acc4 !== 4'hA) begin
         n_err++; $display("FAIL cma: acc got %h want a", acc4);
      end
      go4(4'hD, 4'h0, 4'hF);
      go4(4'hF, 4'h2, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'h0, 1'b1}) begin
         n_err++; $display("FAIL iac_wrap: acc,cy got %h %b want 0 1", acc4, cy4);
      end
      go4(4'hF, 4'h7, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'h1, 1'b0}) begin
         n_err++; $display("FAIL tcc: acc,cy got %h %b want 1 0", acc4, cy4);
      end
      go4(4'hF, 4'h0, 4'h0);
      go4(4'hF, 4'h8, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'hF, 1'b0}) begin
         n_err++; $display("FAIL dac_zero: acc,cy got %h %b want f 0", acc4, cy4);
      end
      go4(4'hF, 4'h8, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'hE, 1'b1}) begin
         n_err++; $display("FAIL dac: acc,cy got %h %b want e 1", acc4, cy4);
      end
      go4(4'hF, 4'h3, 4'h0);
      n_cmp++;
      if (cy4 !== 1'b0) begin
         n_err++; $display("FAIL cmc: cy got %b want 0", cy4);
      end
      go4(4'hF, 4'hA, 4'h0);
      go4(4'hF, 4'h1, 4'h0);
      n_cmp++;
      if ({acc4, cy4} !== {4'hE, 1'b0}) begin
         n_err++; $display("FAIL clc: acc,cy got %h %b want e 0", acc4, cy4);
      end
      go4(4'h0, 4'h0, 4'h5);
      n_cmp++;
      if ({ov4, acc4, cy4, res4} !== {1'b1, 4'hE, 1'b0, 4'hE}) begin
         n_err++; $display("FAIL nop: ov,acc,cy,res got %b %h %b %h want 1 e 0 e", ov4, acc4, cy4, res4);
      end
   endtask

   task automatic test_back_to_back;
      go4(4'hF, 4'h0, 4'h0);
      v4 = 1'b1; op4 = 4'hD; sub4 = 4'h0; opa4 = 4'h2;
      @(posedge clk); #1;
      n_cmp++;
      if ({ov4, acc4, rdy4} !== {1'b1, 4'h2, 1'b1}) begin
         n_err++; $display("FAIL b2b_first: ov,acc,rdy got %b %h %b want 1 2 1", ov4, acc4, rdy4);
      end
      op4 = 4'h8; opa4 = 4'h3;
      @(posedge clk); #1;
      v4 = 1'b0;
      n_cmp++;
      if ({ov4, acc4, cy4} !== {1'b1, 4'h5, 1'b0}) begin
         n_err++; $display("FAIL b2b_second: ov,acc,cy got %b %h %b want 1 5 0", ov4, acc4, cy4);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ov4, acc4} !== {1'b0, 4'h5}) begin
         n_err++; $display("FAIL b2b_idle: ov,acc got %b %h want 0 5", ov4, acc4);
      end
   endtask

   task automatic test_bcd4;
      logic [3:0] e_acc;
      logic       e_cy;
      go4(4'hF, 4'h0, 4'h0);
      go4(4'hD, 4'h0, 4'hB);
      go4(4'hF, 4'hB, 4'h0);
`ifdef ACC_ALU_BCD_EN
      n_cmp++;
      if ({ov4, busy4, rdy4} !== {1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL daa4_busy: ov,busy,rdy got %b %b %b want 0 1 0", ov4, busy4, rdy4);
      end
      @(posedge clk); #1;
      e_acc = 4'h1; e_cy = 1'b1;
`else
      e_acc = 4'hB; e_cy = 1'b0;
`endif
      n_cmp++;
      if ({ov4, acc4, cy4, busy4} !== {1'b1, e_acc, e_cy, 1'b0}) begin
         n_err++; $display("FAIL daa4: ov,acc,cy,busy got %b %h %b %b want 1 %h %b 0", ov4, acc4, cy4, busy4, e_acc, e_cy);
      end
      go4(4'hD, 4'h0, 4'h4);
      go4(4'hF, 4'hC, 4'h0);
`ifdef ACC_ALU_BCD_EN
      e_acc = 4'h3;
`else
      e_acc = 4'h4;
`endif
      n_cmp++;
      if ({ov4, acc4} !== {1'b1, e_acc}) begin
         n_err++; $display("FAIL kbp4: ov,acc got %b %h want 1 %h", ov4, acc4, e_acc);
      end
      go4(4'hD, 4'h0, 4'h5);
      go4(4'hF, 4'hC, 4'h0);
`ifdef ACC_ALU_BCD_EN
      e_acc = 4'hF;
`else
      e_acc = 4'h5;
`endif
      n_cmp++;
      if (acc4 !== e_acc) begin
         n_err++; $display("FAIL kbp5: acc got %h want %h", acc4, e_acc);
      end
   endtask

   task automatic test_bcd8;
      logic [7:0] e_acc;
      logic       e_cy;
      go8(4'hA, 4'h0, 8'h28);
      go8(4'hF, 4'hC, 8'h00);
`ifdef ACC_ALU_BCD_EN
      e_acc = 8'h04;
`else
      e_acc = 8'h28;
`endif
      n_cmp++;
      if ({ov8, acc8} !== {1'b1, e_acc}) begin
         n_err++; $display("FAIL kbp8: ov,acc got %b %h want 1 %h", ov8, acc8, e_acc);
      end
      go8(4'hF, 4'h0, 8'h00);
      go8(4'hA, 4'h0, 8'h9B);
      go8(4'hF, 4'hB, 8'h00);
`ifdef ACC_ALU_BCD_EN
      n_cmp++;
      if ({ov8, busy8, rdy8, acc8} !== {1'b0, 1'b1, 1'b0, 8'h9B}) begin
         n_err++; $display("FAIL daa8_c0: ov,busy,rdy,acc got %b %b %b %h want 0 1 0 9b", ov8, busy8, rdy8, acc8);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ov8, busy8, rdy8, acc8} !== {1'b0, 1'b1, 1'b0, 8'h91}) begin
         n_err++; $display("FAIL daa8_c1: ov,busy,rdy,acc got %b %b %b %h want 0 1 0 91", ov8, busy8, rdy8, acc8);
      end
      @(posedge clk); #1;
      e_acc = 8'h01; e_cy = 1'b1;
`else
      e_acc = 8'h9B; e_cy = 1'b0;
`endif
      n_cmp++;
      if ({ov8, acc8, cy8, res8, busy8, rdy8} !== {1'b1, e_acc, e_cy, e_acc, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL daa8_done: ov,acc,cy,res,busy,rdy got %b %h %b %h %b %b want 1 %h %b %h 0 1",
                           ov8, acc8, cy8, res8, busy8, rdy8, e_acc, e_cy, e_acc);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ov8, busy8} !== {1'b0, 1'b0}) begin
         n_err++; $display("FAIL daa8_after: ov,busy got %b %b want 0 0", ov8, busy8);
      end
   endtask

   task automatic test_daa_reset;
      go8(4'hA, 4'h0, 8'h9B);
      go8(4'hF, 4'hA, 8'h00);
      go8(4'hF, 4'hB, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({acc8, cy8, ov8, rdy8, busy8} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL daa_rst: acc,cy,ov,rdy,busy got %h %b %b %b %b want 00 0 0 1 0", acc8, cy8, ov8, rdy8, busy8);
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({ov8, acc8, cy8, busy8} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL daa_rst_idle%0d: ov,acc,cy,busy got %b %h %b %b want 0 00 0 0", i, ov8, acc8, cy8, busy8);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      v4 = 1'b0; op4 = 4'h0; sub4 = 4'h0; opa4 = 4'h0;
      v8 = 1'b0; op8 = 4'h0; sub8 = 4'h0; opa8 = 8'h00;
      test_reset();
      test_add();
      test_sub();
      test_xch_ral_tcs();
      test_group_ops();
      test_back_to_back();
      test_bcd4();
      test_bcd8();
      test_daa_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
